mccoy_prog_feeder: RTL and testbench
====================================

MCCOY_PROG_FEEDER -- requirements
Module: mccoy_prog_feeder

Interface
REQ-001 Parameter: DEPTH, default 64, program memory depth in 6-bit words, equal to the 6-bit PC range.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load_start  input  1  request to begin a program load (IDLE only).
REQ-005 load_valid  input  1  load_data/load_last valid this cycle.
REQ-006 load_data  input  6  instruction word to store.
REQ-007 load_last  input  1  marks the final word of the load.
REQ-008 load_ready  output  1  feeder accepts a word this cycle.
REQ-009 run  input  1  level request to execute the stored program.
REQ-010 pc  input  6  PC reported by the core.
REQ-011 instr  output  6  instruction presented to the core's instruction pins.
REQ-012 core_reset  output  1  drives the core's reset pin.
REQ-013 prog_len  output  7  number of stored words, 0..64.
REQ-014 state  output  2  current FSM state code.
REQ-015 cycles  output  8  RUN cycle count, saturating.

Function
REQ-016 The FSM SHALL have four states: IDLE=00, LOAD=01, RUN=10, HALT=11.
REQ-017 In IDLE, load_start=1 SHALL go to LOAD; this clears wr_ptr and prog_len.
REQ-018 In IDLE, load_start=0, run=1 and prog_len!=0 SHALL go to RUN and clear cycles.
REQ-019 In IDLE, when load_start and run are both asserted, load_start SHALL win.
REQ-020 In IDLE, run=1 with prog_len=0 SHALL keep the FSM in IDLE.
REQ-021 load_ready SHALL be 1 only in LOAD.
- A word transfers on load_valid & load_ready.
- A transfer writes mem[wr_ptr], increments wr_ptr and increments prog_len.
REQ-022 A transfer with load_last=1 SHALL return the FSM to IDLE on the next edge, with the last word stored.
REQ-023 The 64th transfer SHALL end the load (go to IDLE) regardless of load_last; prog_len then reads 64.
- wr_ptr wraps to 0 but is not reused.
REQ-024 load_valid=0 in LOAD SHALL hold the state with no write, for any number of cycles.
REQ-025 core_reset SHALL be 0 only in RUN and 1 in every other state.
REQ-026 In RUN, instr SHALL equal mem[pc] combinationally (zero-cycle latency from pc).
REQ-027 Outside RUN, instr SHALL be 6'b000000.
REQ-028 In RUN, pc >= prog_len SHALL go to HALT on that edge.
- instr still shows mem[pc] during that cycle.
- With prog_len=64 this condition never fires.
REQ-029 In RUN, run=0 SHALL go to IDLE; this takes priority over the REQ-028 halt.
REQ-030 In HALT, run=0 SHALL go to IDLE; run=1 SHALL hold HALT.
REQ-031 cycles SHALL increment by 1 on every RUN cycle, saturate at 255, and hold its value in HALT and IDLE.
REQ-032 The memory SHALL be written only in LOAD and SHALL retain its contents across RUN, HALT and IDLE.
REQ-033 A new load SHALL overwrite words from address 0; words beyond the new prog_len keep their stale data but are never presented to the core.

Reset
REQ-034 Reset SHALL apply these values:
- state=IDLE, wr_ptr=0, prog_len=0, cycles=0.
- core_reset=1, load_ready=0, instr=0.
REQ-035 Reset SHALL take priority over every transition, including mid-LOAD and mid-RUN.
REQ-036 Memory contents SHALL NOT be reset, but prog_len=0 makes them unreachable.

Structure
REQ-037 The state encodings, DEPTH and the NOP word (6'b000000) SHALL live in the shared McCoy package.
REQ-038 The program memory SHALL be one sub-module, mccoy_prog_mem:
- 64x6 registers;
- one synchronous write port;
- one asynchronous read port.
REQ-039 The FSM, counters and output muxing SHALL reside in mccoy_prog_feeder.

Verification
REQ-040 The bench SHALL cover these directed scenarios:
- Load 3 words (0x05, 0x12, 0x3F; last on the third), then run → prog_len=3, core_reset=0, instr follows pc 0,1,2; pc=3 → HALT, instr=0.
- Load with load_valid toggled 1,0,0,1,1(last) → exactly 3 writes, prog_len=3, load_ready high throughout LOAD.
- Stream 64 words with load_last never asserted → IDLE after the 64th, prog_len=64; RUN with pc sweeping 0..63 never halts.
- load_start and run asserted together in IDLE → LOAD.
- run with prog_len=0 → stays IDLE, core_reset=1.
- Reset asserted after 2 of 5 words in LOAD → IDLE, prog_len=0, wr_ptr=0.
- Reset asserted in RUN at cycles=10 → cycles=0, core_reset=1.
- RUN for 300 cycles with pc held at 0 and prog_len=5 → cycles saturates at 255.
- Drop run → IDLE, cycles holds 255.

Source files
------------

// File: rtl/mccoy_prog_feeder_pkg.sv
// Shared McCoy definitions: FSM state codes, program depth and the NOP word.
package mccoy_prog_feeder_pkg;
  localparam int          DEPTH  = 64;
  localparam int          PC_W   = 6;
  localparam int          WORD_W = 6;
  localparam int          LEN_W  = 7;
  localparam logic [5:0]  NOP    = 6'b000000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;
endpackage

// File: rtl/mccoy_prog_mem.sv
// Program store: register array with one synchronous write port and one
// combinational read port so the core sees mem[pc] in the same cycle.
module mccoy_prog_mem #(
  parameter int DEPTH  = mccoy_prog_feeder_pkg::DEPTH,
  parameter int ADDR_W = mccoy_prog_feeder_pkg::PC_W,
  parameter int WORD_W = mccoy_prog_feeder_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [DEPTH-1:0][WORD_W-1:0] mem;

  // No reset: contents are unreachable until prog_len is rebuilt by a load.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/mccoy_prog_feeder.sv
// Loads a program into local memory, then feeds it to a core by its PC while
// holding the core in reset outside RUN.
module mccoy_prog_feeder #(
  parameter int DEPTH = mccoy_prog_feeder_pkg::DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [5:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic       run,
  input  logic [5:0] pc,
  output logic [5:0] instr,
  output logic       core_reset,
  output logic [6:0] prog_len,
  output logic [1:0] state,
  output logic [7:0] cycles
);
  import mccoy_prog_feeder_pkg::*;

  state_t     st, st_nx;
  logic [5:0] wr_ptr;
  logic [6:0] len_q;
  logic [7:0] cyc_q;
  logic [5:0] rd_word;
  logic       xfer, last_slot, pc_oob;

  assign xfer      = (st == LOAD) && load_valid;
  assign last_slot = (len_q == 7'(DEPTH - 1));
  // With a full 64-word program this compare can never be true.
  assign pc_oob    = ({1'b0, pc} >= len_q);

  always_comb begin
    st_nx = st;
    case (st)
      IDLE: if (load_start)                 st_nx = LOAD;
            else if (run && len_q != '0)    st_nx = RUN;
      LOAD: if (xfer && (load_last || last_slot)) st_nx = IDLE;
      RUN:  if (!run)                       st_nx = IDLE;
            else if (pc_oob)                st_nx = HALT;
      HALT: if (!run)                       st_nx = IDLE;
      default:                              st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= IDLE;
      wr_ptr <= '0;
      len_q  <= '0;
      cyc_q  <= '0;
    end else begin
      st <= st_nx;
      if (st == IDLE && load_start) begin
        wr_ptr <= '0;
        len_q  <= '0;
      end
      if (xfer) begin
        wr_ptr <= wr_ptr + 6'd1;
        len_q  <= len_q + 7'd1;
      end
      if (st == IDLE && st_nx == RUN)     cyc_q <= '0;
      else if (st == RUN && cyc_q != '1)  cyc_q <= cyc_q + 8'd1;
    end
  end

  mccoy_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (xfer),
    .waddr (wr_ptr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rd_word)
  );

  assign load_ready = (st == LOAD);
  assign core_reset = (st != RUN);
  assign instr      = (st == RUN) ? rd_word : NOP;
  assign prog_len   = len_q;
  assign state      = st;
  assign cycles     = cyc_q;
endmodule

// File: tb/tb_mccoy_prog_feeder.sv
// Directed scenarios plus randomized traffic, every cycle compared against a
// behavioural model of the feeder held in plain ints and arrays.
module tb_mccoy_prog_feeder;
  logic       clk = 1'b0;
  logic       reset, load_start, load_valid, load_last, run;
  logic [5:0] load_data, pc;
  logic       load_ready, core_reset;
  logic [5:0] instr;
  logic [6:0] prog_len;
  logic [1:0] state;
  logic [7:0] cycles;

  int n_chk = 0, n_fail = 0;

  // model: mode 0 idle, 1 load, 2 run, 3 halt
  int m_mode = 0, m_len = 0, m_wp = 0, m_cyc = 0;
  int m_mem[64];
  bit m_known[64];
  bit m_live = 0;

  mccoy_prog_feeder dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .run(run), .pc(pc), .instr(instr), .core_reset(core_reset),
    .prog_len(prog_len), .state(state), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_len = 0; m_wp = 0; m_cyc = 0; m_live = 1;
    end else if (m_live) begin
      case (m_mode)
        0: if (load_start) begin m_mode = 1; m_len = 0; m_wp = 0; end
           else if (run && m_len > 0) begin m_mode = 2; m_cyc = 0; end
        1: if (load_valid) begin
             m_mem[m_wp] = load_data; m_known[m_wp] = 1;
             m_wp = (m_wp + 1) % 64; m_len++;
             if (load_last || m_len == 64) m_mode = 0;
           end
        2: begin
             if (m_cyc < 255) m_cyc++;
             if (!run) m_mode = 0;
             else if (pc >= m_len) m_mode = 3;
           end
        default: if (!run) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) if (m_live) begin
    chk("state", state, m_mode);
    chk("load_ready", load_ready, m_mode == 1);
    chk("core_reset", core_reset, m_mode != 2);
    chk("prog_len", prog_len, m_len);
    chk("cycles", cycles, m_cyc);
    if (m_mode != 2) chk("instr_nop", instr, 0);
    else if (m_known[pc]) chk("instr_run", instr, m_mem[pc]);
  end

  task automatic set_in(input logic ls, lv, input logic [5:0] d, input logic lst,
                        input logic r, input logic [5:0] p, input logic rst);
    load_start = ls; load_valid = lv; load_data = d; load_last = lst;
    run = r; pc = p; reset = rst;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic ls, lv, input logic [5:0] d, input logic lst,
                       input logic r, input logic [5:0] p, input logic rst);
    set_in(ls, lv, d, lst, r, p, rst);
    step();
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 1);
    step(); step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_state", state, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_instr", instr, 0);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_cycles", cycles, 0);

    // 3-word load then run
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("load_entered", load_ready, 1);
    drive(0, 1, 6'h05, 0, 0, 0, 0);
    drive(0, 1, 6'h12, 0, 0, 0, 0);
    drive(0, 1, 6'h3F, 1, 0, 0, 0);
    chk("len3", prog_len, 3);
    chk("idle_after_last", state, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    set_in(0, 0, 0, 0, 1, 0, 0); #1;
    chk("run_core_reset", core_reset, 0);
    chk("instr_pc0", instr, 6'h05);
    step();
    set_in(0, 0, 0, 0, 1, 1, 0); #1; chk("instr_pc1", instr, 6'h12); step();
    set_in(0, 0, 0, 0, 1, 2, 0); #1; chk("instr_pc2", instr, 6'h3F); step();
    drive(0, 0, 0, 0, 1, 3, 0);
    chk("halt_state", state, 3);
    chk("halt_instr", instr, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("halt_to_idle", state, 0);

    // gapped load: valid 1,0,0,1,1(last)
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 6'h21, 0, 0, 0, 0);
    drive(0, 0, 6'h2A, 0, 0, 0, 0);
    chk("gap_ready", load_ready, 1);
    drive(0, 0, 6'h2B, 0, 0, 0, 0);
    drive(0, 1, 6'h22, 0, 0, 0, 0);
    drive(0, 1, 6'h23, 1, 0, 0, 0);
    chk("gap_len", prog_len, 3);
    drive(0, 0, 0, 0, 1, 0, 0);
    set_in(0, 0, 0, 0, 1, 1, 0); #1; chk("gap_word1", instr, 6'h22); step();
    drive(0, 0, 0, 0, 0, 0, 0);

    // 64 words without load_last
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) drive(0, 1, 6'(i ^ 6'h2A), 0, 0, 0, 0);
    chk("full_idle", state, 0);
    chk("full_len", prog_len, 64);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 64; i++) drive(0, 0, 0, 0, 1, 6'(i), 0);
    chk("full_never_halts", state, 2);
    drive(0, 0, 0, 0, 0, 0, 0);

    // load_start beats run, reset mid-load, run with empty program
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("start_wins", state, 1);
    drive(0, 1, 6'h01, 0, 0, 0, 0);
    drive(0, 1, 6'h02, 0, 0, 0, 0);
    drive(0, 1, 6'h03, 0, 0, 0, 1);
    chk("rst_load_state", state, 0);
    chk("rst_load_len", prog_len, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("empty_run_idle", state, 0);
    chk("empty_run_core_reset", core_reset, 1);

    // reset mid-run at cycles=10
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 6'(i + 7), i == 4, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1, 0, 0);
    chk("cycles10", cycles, 10);
    drive(0, 0, 0, 0, 1, 0, 1);
    chk("rst_run_cycles", cycles, 0);
    chk("rst_run_core_reset", core_reset, 1);

    // saturation
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 6'(i + 9), i == 4, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) drive(0, 0, 0, 0, 1, 0, 0);
    chk("cycles_sat", cycles, 255);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("drop_run_idle", state, 0);
    chk("cycles_hold", cycles, 255);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 6'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) != 0,
            ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 6)),
            $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
